// File: rtl/platform_led_dimmer_if.sv
// Avalon-MM slave bus carrying register accesses into the LED dimmer.
// Zero wait states: readdata is combinational from address/chipselect.
// No backpressure: every access completes in the cycle it is presented.
interface platform_led_dimmer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/platform_led_dimmer.sv
// PWM brightness + per-LED blink stage between the LED PIO and the board pins.
// Latency: led_out is registered, 1 clk after led_in and after pwm/blink state.
// No backpressure: register writes land at the next clk edge, reads are free.
module platform_led_dimmer #(
  parameter int NUM_LEDS = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  platform_led_dimmer_if.slave bus,
  input  logic [NUM_LEDS-1:0] led_in,
  output logic [NUM_LEDS-1:0] led_out
);

  logic                en_q,          en_d;
  logic [7:0]          bright_q,      bright_d;
  logic [15:0]         prescale_q,    prescale_d;
  logic [NUM_LEDS-1:0] blink_mask_q,  blink_mask_d;
  logic [7:0]          blink_half_q,  blink_half_d;
  logic [15:0]         pre_cnt_q,     pre_cnt_d;
  logic [7:0]          pwm_cnt_q,     pwm_cnt_d;
  logic [7:0]          blink_cnt_q,   blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [7:0]          duty_act_q,    duty_act_d;
  logic [NUM_LEDS-1:0] led_out_q,     led_out_d;

  logic        wr_en;
  logic        wr_ctrl, wr_bright, wr_prescale, wr_mask, wr_half;
  logic        tick, period_end, pwm_on;
  logic [31:0] rdata;
  logic        unused_wdata;

  assign wr_en       = bus.chipselect & ~bus.write_n;
  assign wr_ctrl     = wr_en & (bus.address == 3'd0);
  assign wr_bright   = wr_en & (bus.address == 3'd1);
  assign wr_prescale = wr_en & (bus.address == 3'd2);
  assign wr_mask     = wr_en & (bus.address == 3'd3);
  assign wr_half     = wr_en & (bus.address == 3'd4);
  assign unused_wdata = ^bus.writedata[31:16];

  // Counters only run while enabled, so tick is gated by EN.
  assign tick       = en_q & (pre_cnt_q == prescale_q);
  assign period_end = tick & (pwm_cnt_q == 8'd254);
  assign pwm_on     = (duty_act_q == 8'hFF) | (pwm_cnt_q < duty_act_q);

  // Combinational register readback; unmapped addresses and bits read 0.
  always_comb begin
    rdata = '0;
    case (bus.address)
      3'd0: rdata[0] = en_q;
      3'd1: rdata[7:0] = bright_q;
      3'd2: rdata[15:0] = prescale_q;
      3'd3: rdata[NUM_LEDS-1:0] = blink_mask_q;
      3'd4: rdata[7:0] = blink_half_q;
      3'd5: rdata[9:0] = {en_q, blink_phase_q, pwm_cnt_q};
      default: rdata = '0;
    endcase
  end
  assign bus.readdata = rdata;

  // Next-state: register writes take priority over counter events.
  always_comb begin
    en_d          = wr_ctrl     ? bus.writedata[0]          : en_q;
    bright_d      = wr_bright   ? bus.writedata[7:0]        : bright_q;
    prescale_d    = wr_prescale ? bus.writedata[15:0]       : prescale_q;
    blink_mask_d  = wr_mask     ? bus.writedata[NUM_LEDS-1:0] : blink_mask_q;
    blink_half_d  = wr_half     ? bus.writedata[7:0]        : blink_half_q;

    // Prescaler wraps on tick; held at 0 when disabled or PRESCALE rewritten.
    if (!en_q || wr_prescale || tick) pre_cnt_d = '0;
    else                              pre_cnt_d = pre_cnt_q + 16'd1;

    // PWM counter runs 0..254, advancing one step per tick.
    if (!en_q)           pwm_cnt_d = '0;
    else if (period_end) pwm_cnt_d = '0;
    else if (tick)       pwm_cnt_d = pwm_cnt_q + 8'd1;
    else                 pwm_cnt_d = pwm_cnt_q;

    // Blink phase toggles every BLINK_HALF PWM periods; HALF=0 parks it on.
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (wr_half || !en_q) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (period_end) begin
      if (blink_half_q == 8'd0) begin
        blink_cnt_d   = '0;
        blink_phase_d = 1'b1;
      end else if (blink_cnt_q == blink_half_q - 8'd1) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + 8'd1;
      end
    end

    // Duty is shadowed so a BRIGHT write never disturbs the running period.
    duty_act_d = (!en_q || period_end) ? bright_q : duty_act_q;

    if (en_q)
      led_out_d = led_in & {NUM_LEDS{pwm_on}} & ~(blink_mask_q & {NUM_LEDS{~blink_phase_q}});
    else
      led_out_d = led_in;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q          <= 1'b0;
      bright_q      <= 8'hFF;
      prescale_q    <= '0;
      blink_mask_q  <= '0;
      blink_half_q  <= '0;
      pre_cnt_q     <= '0;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      duty_act_q    <= 8'hFF;
      led_out_q     <= '0;
    end else begin
      en_q          <= en_d;
      bright_q      <= bright_d;
      prescale_q    <= prescale_d;
      blink_mask_q  <= blink_mask_d;
      blink_half_q  <= blink_half_d;
      pre_cnt_q     <= pre_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      duty_act_q    <= duty_act_d;
      led_out_q     <= led_out_d;
    end
  end

  assign led_out = led_out_q;

endmodule
